// File: rtl/am_param_meas_pkg.sv
// Shared types and constants for the AM parameter measurement stage.
package am_meas_pkg;

   localparam int ENV_W     = 9;
   localparam int DIV_W     = 16;
   localparam int PCT_SCALE = 100;

   typedef enum logic [2:0] {
      MS_IDLE    = 3'd0,
      MS_ACQ     = 3'd1,
      MS_CALC_MA = 3'd2,
      MS_CALC_F  = 3'd3,
      MS_DONE    = 3'd4
   } meas_state_e;

   function automatic logic [7:0] sat8(input logic [DIV_W-1:0] v);
      return (v > DIV_W'(255)) ? 8'hFF : v[7:0];
   endfunction

endpackage

// File: rtl/am_param_meas_seq_div.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per clock.
module seq_div
   import am_meas_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [DIV_W-1:0] dividend_i,
   input  logic [DIV_W-1:0] divisor_i,
   output logic             done_o,
   output logic [DIV_W-1:0] quotient_o,
   output logic [DIV_W-1:0] remainder_o
);

   logic             busy_q;
   logic [3:0]       cnt_q;
   logic [DIV_W-1:0] dvd_q, dvs_q, rem_q;
   logic [DIV_W:0]   rem_sh;
   logic             ge;
   logic [DIV_W-1:0] rem_n, quo_n;

   // The dividend register shifts left and collects quotient bits in its LSB.
   always_comb begin
      rem_sh = {rem_q, dvd_q[DIV_W-1]};
      ge     = rem_sh >= {1'b0, dvs_q};
      rem_n  = ge ? DIV_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[DIV_W-1:0];
      quo_n  = {dvd_q[DIV_W-2:0], ge};
   end

   // Results are forwarded during the final iteration so done carries them.
   assign done_o      = busy_q && (cnt_q == 4'(DIV_W-1));
   assign quotient_o  = done_o ? quo_n : dvd_q;
   assign remainder_o = done_o ? rem_n : rem_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
      end else if (!busy_q && start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         dvd_q  <= dividend_i;
         dvs_q  <= divisor_i;
         rem_q  <= '0;
      end else if (busy_q) begin
         dvd_q <= quo_n;
         rem_q <= rem_n;
         cnt_q <= cnt_q + 4'd1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/am_param_meas.sv
// Per-window modulation depth (percent) and modulating frequency (kHz) from
// the demodulated envelope.
module am_param_meas
   import am_meas_pkg::*;
#(
   parameter int WIN_CYC = 81920,
   parameter int WIN_MS  = 10,
   parameter int OFFSET  = 512,
   parameter int HYST    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [9:0] din,
   input  logic       din_valid,
   output logic [7:0] ma,
   output logic [7:0] freq,
   output logic       meas_valid,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int CNT_W = $clog2(WIN_CYC);
   localparam logic [2:0] ST_IDLE    = MS_IDLE;
   localparam logic [2:0] ST_ACQ     = MS_ACQ;
   localparam logic [2:0] ST_CALC_MA = MS_CALC_MA;
   localparam logic [2:0] ST_CALC_F  = MS_CALC_F;
   localparam logic [2:0] ST_DONE    = MS_DONE;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
   logic [ENV_W-1:0] vmax_q, vmax_d, vmin_q, vmin_d;
   logic [ENV_W-1:0] vmax_prev_q, vmax_prev_d, vmin_prev_q, vmin_prev_d;
   logic             have_prev_q, have_prev_d, level_q, level_d;
   logic [7:0]       xcnt_q, xcnt_d, ma_res_q, ma_res_d;
   logic [7:0]       ma_q, ma_d, freq_q, freq_d;
   logic             mv_q, mv_d;

   logic [9:0]       off_c, env10, mid10;
   logic [ENV_W-1:0] env, span;
   logic             env_hi, env_lo;
   logic [DIV_W-1:0] den_ma, div_num, div_den, div_quo;
   logic             div_start, div_done;

   // Clamp the offset-binary sample to a non-negative envelope.
   always_comb begin
      off_c  = 10'(OFFSET);
      env    = (din > off_c) ? ENV_W'(din - off_c) : '0;
      env10  = {1'b0, env};
      mid10  = ({1'b0, vmax_prev_q} + {1'b0, vmin_prev_q}) >> 1;
      env_hi = env10 > (mid10 + 10'(HYST));
      env_lo = (env10 + 10'(HYST)) < mid10;
      // An empty window leaves vmax below vmin; treat it as zero depth.
      span   = (vmax_q >= vmin_q) ? (vmax_q - vmin_q) : '0;
      den_ma = DIV_W'(vmax_q) + DIV_W'(vmin_q);
   end

   always_comb begin
      div_start = 1'b0;
      div_num   = DIV_W'(span) * DIV_W'(PCT_SCALE);
      div_den   = den_ma;
      if (state_q == ST_CALC_MA) begin
         div_start = (den_ma != '0);
      end else if (state_q == ST_CALC_F) begin
         div_start = 1'b1;
         div_num   = DIV_W'(xcnt_q) + DIV_W'(WIN_MS / 2);
         div_den   = DIV_W'(WIN_MS);
      end
   end

   seq_div u_div (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (div_start),
      .dividend_i  (div_num),
      .divisor_i   (div_den),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o ()
   );

   always_comb begin
      state_d     = state_q;
      win_cnt_d   = win_cnt_q;
      vmax_d      = vmax_q;
      vmin_d      = vmin_q;
      vmax_prev_d = vmax_prev_q;
      vmin_prev_d = vmin_prev_q;
      have_prev_d = have_prev_q;
      level_d     = level_q;
      xcnt_d      = xcnt_q;
      ma_res_d    = ma_res_q;
      ma_d        = ma_q;
      freq_d      = freq_q;
      mv_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d     = ST_ACQ;
               win_cnt_d   = '0;
               vmax_d      = '0;
               vmin_d      = '1;
               xcnt_d      = '0;
               have_prev_d = 1'b0;
               level_d     = 1'b0;
            end
         end
         ST_ACQ: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else begin
               if (din_valid) begin
                  if (env > vmax_q) vmax_d = env;
                  if (env < vmin_q) vmin_d = env;
                  if (have_prev_q) begin
                     if (env_hi && !level_q) begin
                        level_d = 1'b1;
                        if (xcnt_q != 8'hFF) xcnt_d = xcnt_q + 8'd1;
                     end else if (env_lo) begin
                        level_d = 1'b0;
                     end
                  end
               end
               if (win_cnt_q == CNT_W'(WIN_CYC - 1)) state_d = ST_CALC_MA;
               else win_cnt_d = win_cnt_q + 1'b1;
            end
         end
         ST_CALC_MA: begin
            if (den_ma == '0) begin
               ma_res_d = '0;
               state_d  = ST_CALC_F;
            end else if (div_done) begin
               ma_res_d = (div_quo > DIV_W'(PCT_SCALE)) ? 8'(PCT_SCALE) : div_quo[7:0];
               state_d  = ST_CALC_F;
            end
         end
         ST_CALC_F: begin
            if (div_done) begin
               ma_d        = ma_res_q;
               freq_d      = sat8(div_quo);
               mv_d        = 1'b1;
               vmax_prev_d = vmax_q;
               vmin_prev_d = vmin_q;
               have_prev_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (en) begin
               state_d   = ST_ACQ;
               win_cnt_d = '0;
               vmax_d    = '0;
               vmin_d    = '1;
               xcnt_d    = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         win_cnt_q   <= '0;
         vmax_q      <= '0;
         vmin_q      <= '0;
         vmax_prev_q <= '0;
         vmin_prev_q <= '0;
         have_prev_q <= 1'b0;
         level_q     <= 1'b0;
         xcnt_q      <= '0;
         ma_res_q    <= '0;
         ma_q        <= '0;
         freq_q      <= '0;
         mv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         vmax_q      <= vmax_d;
         vmin_q      <= vmin_d;
         vmax_prev_q <= vmax_prev_d;
         vmin_prev_q <= vmin_prev_d;
         have_prev_q <= have_prev_d;
         level_q     <= level_d;
         xcnt_q      <= xcnt_d;
         ma_res_q    <= ma_res_d;
         ma_q        <= ma_d;
         freq_q      <= freq_d;
         mv_q        <= mv_d;
      end
   end

   assign ma         = ma_q;
   assign freq       = freq_q;
   assign meas_valid = mv_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_am_param_meas.sv
// Directed bench for am_param_meas using a shortened window and triangle envelopes.
module tb_am_param_meas;

   localparam int WIN = 1000;
   localparam int LAT = WIN + 35;
   localparam int LATZ = WIN + 19;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [9:0] din = 10'd0;
   logic       din_valid = 1'b0;
   logic [7:0] ma, freq;
   logic       meas_valid, busy;
   logic [2:0] dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int mode = 0;
   int ph = 0;
   logic [15:0] exp_q[$];

   am_param_meas #(.WIN_CYC(WIN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .din_valid  (din_valid),
      .ma         (ma),
      .freq       (freq),
      .meas_valid (meas_valid),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] tri_wave(input int lo, input int hi, input int per, input int p);
      int h, a;
      h = per / 2;
      a = ((p % per) < h) ? (p % per) : (per - (p % per));
      return 10'(512 + lo + ((hi - lo) * a) / h);
   endfunction

   // 0: flat 700, 1: 100..300 @ "2 kHz", 2: 0..400 @ "5 kHz", 3: 0..400 @ "3.3 kHz", 4: below offset
   function automatic logic [9:0] wave(input int m, input int p);
      case (m)
         1:       return tri_wave(100, 300, 50, p);
         2:       return tri_wave(0, 400, 20, p);
         3:       return tri_wave(0, 400, 30, p);
         4:       return 10'd400;
         default: return 10'd700;
      endcase
   endfunction

   // Advance one clock; outputs are sampled 1 ns after the edge, then inputs change.
   task automatic step();
      @(posedge clk);
      #1;
      ph++;
      din_valid = ((ph % 7) != 3);
      din = din_valid ? wave(mode, ph) : 10'd1023;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!meas_valid && n < budget);
   endtask

   task automatic meas_window(input string tag, input int exp_cyc, input logic [7:0] exp_ma,
                              input logic [7:0] exp_freq);
      int n;
      logic [15:0] e;
      exp_q.push_back({exp_ma, exp_freq});
      wait_valid(exp_cyc + 100, n);
      e = exp_q.pop_front();
      expect_eq({tag, ".lat"}, n, exp_cyc);
      expect_eq({tag, ".ma"}, ma, e[15:8]);
      expect_eq({tag, ".freq"}, freq, e[7:0]);
   endtask

   initial begin
      logic seen;
      repeat (3) @(posedge clk);
      #1;
      expect_eq("rst.ma", ma, 0);
      expect_eq("rst.freq", freq, 0);
      expect_eq("rst.valid", meas_valid, 0);
      expect_eq("rst.busy", busy, 0);
      expect_eq("rst.state", dbg_state, 0);

      rst_n = 1'b1;
      en = 1'b1;
      mode = 0;
      meas_window("const_a", LAT, 0, 0);
      meas_window("const_b", LAT, 0, 0);

      mode = 1;
      meas_window("am50_a", LAT, 50, 2);
      meas_window("am50_b", LAT, 50, 2);

      mode = 2;
      meas_window("am100_5k_a", LAT, 100, 5);
      meas_window("am100_5k_b", LAT, 100, 5);

      mode = 3;
      meas_window("am100_3k3_a", LAT, 100, 3);
      meas_window("am100_3k3_b", LAT, 100, 3);

      mode = 4;
      meas_window("zero_a", LATZ, 0, 0);
      meas_window("zero_b", LATZ, 0, 0);

      // Threshold inherited from the zero window sits at 0, so no full crossing.
      mode = 1;
      meas_window("am50_after_zero", LAT, 50, 0);
      meas_window("am50_c", LAT, 50, 2);

      repeat (WIN / 2) step();
      en = 1'b0;
      step();
      expect_eq("abort.busy", busy, 0);
      expect_eq("abort.state", dbg_state, 0);
      seen = 1'b0;
      repeat (200) begin
         step();
         if (meas_valid) seen = 1'b1;
      end
      expect_eq("abort.no_valid", seen, 0);
      expect_eq("abort.ma_hold", ma, 50);
      expect_eq("abort.freq_hold", freq, 2);

      en = 1'b1;
      meas_window("reen_a", LAT, 50, 0);
      meas_window("reen_b", LAT, 50, 2);

      repeat (WIN + 5) step();
      en = 1'b0;
      meas_window("calc_drop", 30, 50, 2);
      step();
      expect_eq("calc_drop.busy", busy, 0);

      en = 1'b1;
      meas_window("pre_rst", LAT, 50, 0);
      repeat (WIN + 5) step();
      rst_n = 1'b0;
      #1;
      expect_eq("calc_rst.ma", ma, 0);
      expect_eq("calc_rst.freq", freq, 0);
      expect_eq("calc_rst.valid", meas_valid, 0);
      expect_eq("calc_rst.busy", busy, 0);
      repeat (3) step();
      rst_n = 1'b1;
      meas_window("post_rst", LAT, 50, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
